// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared encodings and limits for the sized data memory
//
// Contents:
//   SZ_BYTE/SZ_HALF/SZ_WORD  access size encodings (2'd3 is illegal)
//   MAX_LATENCY, CNT_W       response latency ceiling and latency counter width
//   state_t                  request/response FSM states
//   misaligned()             alignment check for a size/lane pair
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Size 3 is reported as misaligned so one test covers every shape error.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane.sv
// rtl/dm_lane.sv - little-endian byte/half/word store merge and load extract
//
// Ports:
//   word         current contents of the addressed word
//   wdata        store data, right-aligned
//   size         SZ_BYTE / SZ_HALF / SZ_WORD (size 3 leaves word untouched, rdata 0)
//   is_unsigned  zero-extend byte/half loads instead of sign-extending
//   lane         byte address bits [1:0]
//   merged       word with the store data merged into the selected lane(s)
//   rdata        selected lane(s) of word, extended to 32 bits
module dm_lane
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    output logic [31:0] merged,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        merged   = word;
        rdata    = '0;
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
                rdata = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
                rdata = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                merged = wdata;
                rdata  = word;
            end
            default: begin
                merged = word;
                rdata  = '0;
            end
        endcase
    end

endmodule

// File: rtl/dm_sized.sv
// rtl/dm_sized.sv - sized data memory with valid/ready requests and fixed-latency responses
//
// Parameters:
//   ADDR_W   word-index width; 2**ADDR_W words, 2**(ADDR_W+2) bytes
//   LATENCY  cycles from request accept edge to the rsp_valid cycle, 1..MAX_LATENCY
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid / req_ready           request handshake
//   req_we, req_size, req_unsigned  store flag, access size, zero-extend loads
//   req_addr, req_wdata, req_pc     byte address, right-aligned store data, trace PC
//   rsp_valid                       one-cycle response pulse
//   rsp_rdata, rsp_err              extended load data (0 for stores/errors), reject flag
// Build option:
//   DM_TRACE_EN  print "@pc: *word_addr <= merged_word" for every committed store
module dm_sized
    import dm_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    logic [31:0]      mem [DEPTH];
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hold_rdata;
    logic             hold_err;

    logic [ADDR_W-1:0] widx;
    logic [31:0]       cur_word;
    logic [31:0]       merged;
    logic [31:0]       ld_data;
    logic              accept;
    logic              range_err;
    logic              acc_err;
    logic [31:0]       rsp_next;

    assign widx      = req_addr[ADDR_W+1:2];
    assign cur_word  = mem[widx];
    assign req_ready = (state == IDLE) || (state == RESP);
    assign accept    = req_valid && req_ready;

    // Any address bit above the byte space makes the access out of range.
    assign range_err = (req_addr >> (ADDR_W + 2)) != 32'd0;
    assign acc_err   = range_err || misaligned(req_size, req_addr[1:0]);

    // Stores and rejected accesses always answer with zero data.
    assign rsp_next  = (req_we || acc_err) ? 32'd0 : ld_data;

    dm_lane u_lane (
        .word        (cur_word),
        .wdata       (req_wdata),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .lane        (req_addr[1:0]),
        .merged      (merged),
        .rdata       (ld_data)
    );

`ifndef DM_TRACE_EN
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state      <= IDLE;
            cnt        <= '0;
            hold_rdata <= '0;
            hold_err   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        if (req_we && !acc_err) begin
                            mem[widx] <= merged;
`ifdef DM_TRACE_EN
                            $display("@%h: *%h <= %h", req_pc, {req_addr[31:2], 2'b00}, merged);
`endif
                        end
                        hold_rdata <= rsp_next;
                        hold_err   <= acc_err;
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rsp_next;
                            rsp_err   <= acc_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= hold_rdata;
                        rsp_err   <= hold_err;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dm_sized.md
Name: dm_sized

Overview:
Parametrised data memory, successor to the single-cycle word-only DM. Supports byte, halfword and word loads/stores, with sign or zero extension on loads. Uses a valid/ready request port and a fixed-latency response port. Detects misaligned and out-of-range accesses. Sits behind the MEM stage of the CPU; latency is configurable so later stall-logic work can be exercised.

Parameters:
ADDR_W, 10, word-index width; depth = 2**ADDR_W words, byte space = 2**(ADDR_W+2)
LATENCY, 1, cycles from request accept edge to rsp_valid cycle; legal 1..15

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  in  1  zero-extend load (lbu/lhu); ignored for word and for stores
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_pc  in  32  PC of the requesting instruction (trace only)
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  access rejected (misaligned, out of range, size 3)

Behaviour:
- Clock and reset: clk, with reset synchronous and active-high, named reset.
- Reset: all memory words = 0. State IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Reset mid-operation drops the pending response; no rsp_valid follows.
- States: IDLE, WAIT, RESP. req_ready = (state==IDLE)||(state==RESP). The consumer always accepts responses; there is no rsp_ready.
- Accept: req_valid&&req_ready at rising edge T.
  - Stores commit to the array at edge T.
  - Load data is extracted and extended at edge T into a holding register.
- Accept transitions:
  - LATENCY==1: next state RESP.
  - Otherwise: next state WAIT with counter=LATENCY-2.
  - WAIT: decrement the counter; when it reaches 0, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, so rsp_valid is in cycle T+LATENCY. A new accept in RESP follows the accept transitions; otherwise go to IDLE. LATENCY=1 therefore gives one request per cycle.
- Lanes are little-endian: byte lane = addr[1:0], half lane = addr[1].
  - Stores merge into the existing word; untouched bytes are unchanged.
  - Loads: lb/lh sign-extend and lbu/lhu zero-extend. A word load returns the full word.
- Errors: any of the following sets rsp_err=1 with rsp_rdata=0, and no array write occurs.
  - size 1 with addr[0]!=0
  - size 2 with addr[1:0]!=0
  - size 3
  - addr[31:ADDR_W+2] != 0
  - The error response uses the same latency and handshake as a normal response.
- Store-then-load to the same word on back-to-back accepts returns the new data, since the store committed at the earlier edge.
- Requests while req_ready=0 are ignored; the requester holds them.

Optional Feature:
DM_TRACE_EN:
- Defined: on each committed store, $display("@%h: *%h <= %h", req_pc, {req_addr[31:2],2'b00}, merged_word). The merged word is the full 32-bit word after the byte/half merge. Nothing is printed for errored stores.
- Undefined: no display statements are compiled; behaviour is otherwise identical.

Decomposition:
- Package dm_pkg holds:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2
  - state typedef {IDLE, WAIT, RESP}
  - MAX_LATENCY=15
- Sub-module dm_lane: purely combinational store-merge (old word, wdata, size, addr[1:0] -> new word) and load-extract (word, size, unsigned, addr[1:0] -> rdata).
- Top module: array, FSM, counter, error check.

Test Plan:
- LATENCY=1: sw 0x12345678 @0x10, then lw @0x10 next cycle -> second rsp_valid one cycle after accept, rdata=0x12345678, err=0.
- sb 0xAB @0x11 over word 0x12345678, then lw @0x10 -> 0x1234AB78; lb @0x11 -> 0xFFFFFFAB; lbu @0x11 -> 0x000000AB.
- sh 0x8001 @0x22, then lh @0x22 -> 0xFFFF8001; lhu -> 0x00008001; lw @0x20 -> 0x80010000.
- lh @0x21, sw @0x02, size 3, lw @0x1000 (ADDR_W=10) -> each rsp_err=1, rdata=0, and memory unchanged (checked via later lw).
- LATENCY=4: accept at cycle 0 -> req_ready=0 in cycles 1-3, rsp_valid only in cycle 4, req_ready=1 in cycle 4; req_valid held high accepts again in cycle 4.
- LATENCY=3: reset in cycle 1 after a sw accept -> no rsp_valid, outputs 0, and a subsequent lw of that address returns 0.
